// File: rtl/fmac_seq.sv
// ---------------------------------------------------------------------------
// fmac_seq -- sequencer for one fmac dot-product datapath.
//
// Purpose:
//   The block pops matched activation/weight blocks from two valid/ready
//   streams. Each block has a shared exponent and N_LANE mantissas. The
//   block issues them to fmac one at a time. Each fmac result is chained
//   back as the next block's prev_result, so that one accumulated dot
//   product comes out per job. The final result is presented on a
//   valid/ready port.
//
// Ports:
//   i_clk, i_reset_n             clock, async active-low reset
//   i_start, i_len               job start pulse and block count (IDLE only)
//   i_abort                      synchronous abort, highest priority
//   o_busy                       high whenever not IDLE
//   i_act_*/o_act_ready          activation stream (E + packed mantissas)
//   i_wgt_*/o_wgt_ready          weight stream (E + packed mantissas)
//   o_fmac_valid, o_fmac_*       issue strobe and registered operands to fmac
//   o_fmac_prev_E/M              running accumulator fed back to fmac
//   i_fmac_result_E/M            fmac result, valid FMAC_LAT cycles after issue
//   o_res_valid/i_res_ready      final result handshake
//   o_res_E/M                    final accumulated exponent / mantissa
// ---------------------------------------------------------------------------
module fmac_seq #(
  parameter int N_LANE   = 16,
  parameter int M_W      = 4,
  parameter int E_W      = 8,
  parameter int ACC_M_W  = 24,
  parameter int FMAC_LAT = 2,
  parameter int LEN_W    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_len,
  input  logic                    i_abort,
  output logic                    o_busy,
  input  logic                    i_act_valid,
  output logic                    o_act_ready,
  input  logic [E_W-1:0]          i_act_E,
  input  logic [N_LANE*M_W-1:0]   i_act_M,
  input  logic                    i_wgt_valid,
  output logic                    o_wgt_ready,
  input  logic [E_W-1:0]          i_wgt_E,
  input  logic [N_LANE*M_W-1:0]   i_wgt_M,
  output logic                    o_fmac_valid,
  output logic [E_W-1:0]          o_fmac_Act_E,
  output logic [E_W-1:0]          o_fmac_Weight_E,
  output logic [N_LANE*M_W-1:0]   o_fmac_Act_M,
  output logic [N_LANE*M_W-1:0]   o_fmac_Weight_M,
  output logic [E_W-1:0]          o_fmac_prev_E,
  output logic [ACC_M_W-1:0]      o_fmac_prev_M,
  input  logic [E_W-1:0]          i_fmac_result_E,
  input  logic [ACC_M_W-1:0]      i_fmac_result_M,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [E_W-1:0]          o_res_E,
  output logic [ACC_M_W-1:0]      o_res_M
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // The wait counter must hold FMAC_LAT-1. It is kept at least 1 bit wide
  // so that FMAC_LAT=1 still elaborates.
  localparam int              CNT_W    = (FMAC_LAT > 1) ? $clog2(FMAC_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(FMAC_LAT - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_pop;
  logic [LEN_W-1:0]        r_remaining;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic [E_W-1:0]          r_acc_E;
  logic [ACC_M_W-1:0]      r_acc_M;
  logic [E_W-1:0]          r_act_E;
  logic [E_W-1:0]          r_wgt_E;
  logic [N_LANE*M_W-1:0]   r_act_M;
  logic [N_LANE*M_W-1:0]   r_wgt_M;

  // NOTE: every signal written here gets a default value first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_len == '0) ? S_OUT : S_FETCH;
      end
      S_FETCH: begin
        // Both streams pop together or not at all. A lone valid waits.
        if (i_act_valid && i_wgt_valid) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt == '0) w_next = (r_remaining != '0) ? S_FETCH : S_OUT;
      end
      S_OUT: begin
        if (i_res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides every transition and suppresses the pop.
    if (i_abort) begin
      w_next = S_IDLE;
      w_pop  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // register samples the values from before the edge, whatever the order
  // of the statements.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Datapath registers. The operand and accumulator registers drive
  // outputs directly, so they are reset to give all-zero outputs out of
  // reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_remaining <= '0;
      r_wait_cnt  <= '0;
      r_acc_E     <= '0;
      r_acc_M     <= '0;
      r_act_E     <= '0;
      r_wgt_E     <= '0;
      r_act_M     <= '0;
      r_wgt_M     <= '0;
    end else if (!i_abort) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_remaining <= i_len;
            r_acc_E     <= '0;
            r_acc_M     <= '0;
          end
        end
        S_FETCH: begin
          if (w_pop) begin
            r_act_E     <= i_act_E;
            r_act_M     <= i_act_M;
            r_wgt_E     <= i_wgt_E;
            r_wgt_M     <= i_wgt_M;
            r_remaining <= r_remaining - LEN_W'(1);
          end
        end
        S_ISSUE: r_wait_cnt <= LAT_LOAD;
        S_WAIT: begin
          // Count 0 is the cycle FMAC_LAT after issue. The result is
          // valid now and becomes the next block's prev_result.
          if (r_wait_cnt == '0) begin
            r_acc_E <= i_fmac_result_E;
            r_acc_M <= i_fmac_result_M;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_act_ready     = w_pop;
  assign o_wgt_ready     = w_pop;
  assign o_busy          = (r_state != S_IDLE);
  assign o_fmac_valid    = (r_state == S_ISSUE) && !i_abort;
  assign o_fmac_Act_E    = r_act_E;
  assign o_fmac_Act_M    = r_act_M;
  assign o_fmac_Weight_E = r_wgt_E;
  assign o_fmac_Weight_M = r_wgt_M;
  assign o_fmac_prev_E   = r_acc_E;
  assign o_fmac_prev_M   = r_acc_M;
  assign o_res_valid     = (r_state == S_OUT);
  assign o_res_E         = r_acc_E;
  assign o_res_M         = r_acc_M;

endmodule

// File: tb/tb_fmac_seq.sv
// ---------------------------------------------------------------------------
// tb_fmac_seq -- self-checking bench for fmac_seq.
//
// The fmac stub returns M = prev_M + 1 and E = act_E, FMAC_LAT cycles after
// the issue. Outside that cycle it drives junk. Stream items are
// pre-generated random arrays. The reference model is therefore:
//   - the k-th issue carries activation item k and weight item k;
//   - prev_M at the k-th issue of a job equals k;
//   - the final result is M = len, and E = E of the last activation item,
//     or 0/0 for len 0.
// ---------------------------------------------------------------------------
module tb_fmac_seq;
  localparam int N_LANE = 16, M_W = 4, E_W = 8, ACC_M_W = 24, FMAC_LAT = 2, LEN_W = 8;
  localparam int NITEM = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, start, abort, res_ready;
  logic [LEN_W-1:0]      len;
  logic                  act_valid, wgt_valid;
  logic [E_W-1:0]        act_E, wgt_E;
  logic [N_LANE*M_W-1:0] act_M, wgt_M;
  logic                  o_busy, o_act_ready, o_wgt_ready, o_fmac_valid, o_res_valid;
  logic [E_W-1:0]        o_fmac_Act_E, o_fmac_Weight_E, o_fmac_prev_E, o_res_E;
  logic [N_LANE*M_W-1:0] o_fmac_Act_M, o_fmac_Weight_M;
  logic [ACC_M_W-1:0]    o_fmac_prev_M, o_res_M;
  logic [E_W-1:0]        fres_E;
  logic [ACC_M_W-1:0]    fres_M;

  fmac_seq #(.N_LANE(N_LANE), .M_W(M_W), .E_W(E_W), .ACC_M_W(ACC_M_W),
             .FMAC_LAT(FMAC_LAT), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_len(len), .i_abort(abort),
    .o_busy(o_busy),
    .i_act_valid(act_valid), .o_act_ready(o_act_ready), .i_act_E(act_E), .i_act_M(act_M),
    .i_wgt_valid(wgt_valid), .o_wgt_ready(o_wgt_ready), .i_wgt_E(wgt_E), .i_wgt_M(wgt_M),
    .o_fmac_valid(o_fmac_valid), .o_fmac_Act_E(o_fmac_Act_E), .o_fmac_Weight_E(o_fmac_Weight_E),
    .o_fmac_Act_M(o_fmac_Act_M), .o_fmac_Weight_M(o_fmac_Weight_M),
    .o_fmac_prev_E(o_fmac_prev_E), .o_fmac_prev_M(o_fmac_prev_M),
    .i_fmac_result_E(fres_E), .i_fmac_result_M(fres_M),
    .o_res_valid(o_res_valid), .i_res_ready(res_ready), .o_res_E(o_res_E), .o_res_M(o_res_M)
  );

  // fmac stub: a 2-stage pipeline. Junk is driven whenever no result is due.
  logic               s1_v, s2_v;
  logic [E_W-1:0]     s1_E, s2_E;
  logic [ACC_M_W-1:0] s1_M, s2_M;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_E <= '0; s2_E <= '0; s1_M <= '0; s2_M <= '0;
    end else begin
      s1_v <= o_fmac_valid; s1_E <= o_fmac_Act_E; s1_M <= o_fmac_prev_M + 24'd1;
      s2_v <= s1_v;         s2_E <= s1_E;         s2_M <= s1_M;
    end
  end
  assign fres_E = s2_v ? s2_E : 8'hEE;
  assign fres_M = s2_v ? s2_M : 24'hBADBAD;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream sources and reference items.
  logic [E_W-1:0]        a_E [NITEM];
  logic [E_W-1:0]        w_E [NITEM];
  logic [N_LANE*M_W-1:0] a_M [NITEM];
  logic [N_LANE*M_W-1:0] w_M [NITEM];
  int  a_idx = 0, w_idx = 0, cyc = 0, mode = 2, job_issues = 0;
  int  issue_t[$];
  bit  act_pop = 1'b0, wgt_pop = 1'b0;

  always @(posedge clk) begin
    act_pop <= act_valid & o_act_ready;
    wgt_pop <= wgt_valid & o_wgt_ready;
  end

  // Source + issue monitor: 0 = both always valid, 1 = act always and
  // wgt every 3rd cycle, 2 = neither valid.
  initial begin : src
    act_valid = 1'b0; wgt_valid = 1'b0;
    act_E = '0; act_M = '0; wgt_E = '0; wgt_M = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (act_pop) a_idx++;
      if (wgt_pop) w_idx++;
      if (rst_n) begin
        check("rdy_pair", o_act_ready, o_wgt_ready);
        if (o_act_ready) check("rdy_needs_both", act_valid & wgt_valid, 1);
        if (o_fmac_valid) begin
          check("iss_act_E", o_fmac_Act_E,    a_E[a_idx-1]);
          check("iss_act_M", o_fmac_Act_M,    a_M[a_idx-1]);
          check("iss_wgt_E", o_fmac_Weight_E, w_E[w_idx-1]);
          check("iss_wgt_M", o_fmac_Weight_M, w_M[w_idx-1]);
          check("iss_pair_idx", a_idx, w_idx);
          check("iss_prev_M", o_fmac_prev_M, job_issues);
          job_issues++;
          issue_t.push_back(cyc);
        end
      end
      act_valid = (mode != 2);
      wgt_valid = (mode == 0) || (mode == 1 && (cyc % 3) == 0);
      act_E = a_E[a_idx]; act_M = a_M[a_idx];
      wgt_E = w_E[w_idx]; wgt_M = w_M[w_idx];
    end
  end

  int start_a, start_w;

  task automatic start_job(input int n);
    @(negedge clk);
    job_issues = 0;
    issue_t.delete();
    start_a = a_idx; start_w = w_idx;
    start = 1'b1; len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0; len = LEN_W'($urandom);
  endtask

  task automatic wait_res(input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (o_res_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic finish_res(input string tag, input int n);
    logic [E_W-1:0] exp_E;
    exp_E = (n == 0) ? '0 : a_E[start_a + n - 1];
    check({tag, "_busy"},  o_busy, 1);
    check({tag, "_res_M"}, o_res_M, n);
    check({tag, "_res_E"}, o_res_E, exp_E);
    check({tag, "_act_pops"}, a_idx - start_a, n);
    check({tag, "_wgt_pops"}, w_idx - start_w, n);
    check({tag, "_issues"}, job_issues, n);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, o_res_valid, 0);
    check({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin : main
    logic [E_W-1:0]     hold_E;
    logic [ACC_M_W-1:0] hold_M;
    int k, n;
    for (int i = 0; i < NITEM; i++) begin
      a_E[i] = E_W'($urandom); w_E[i] = E_W'($urandom);
      a_M[i] = {$urandom, $urandom}; w_M[i] = {$urandom, $urandom};
    end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0; len = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_res_valid", o_res_valid, 0);
    check("rst_fmac_valid", o_fmac_valid, 0);
    check("rst_res_M", o_res_M, 0);
    rst_n = 1'b1;

    // Basic job: len 4, streams always valid, issues 4 cycles apart.
    mode = 0;
    start_job(4);
    wait_res("len4");
    check("len4_n_issue", issue_t.size(), 4);
    for (int i = 1; i < issue_t.size(); i++)
      check("len4_spacing", issue_t[i] - issue_t[i-1], FMAC_LAT + 2);
    finish_res("len4", 4);

    // len 0: result 0/0 one cycle after start, no pops.
    start_job(0);
    check("len0_fast_valid", o_res_valid, 1);
    finish_res("len0", 0);

    // Weight valid only every 3rd cycle.
    mode = 1;
    n = $urandom_range(3, 6);
    start_job(n);
    wait_res("sparse");
    finish_res("sparse", n);

    // Result backpressure: values stable, start ignored, busy held.
    mode = 0;
    start_job(2);
    wait_res("hold");
    hold_E = o_res_E; hold_M = o_res_M;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 8'd7;
      @(negedge clk);
      check("hold_valid", o_res_valid, 1);
      check("hold_busy", o_busy, 1);
      check("hold_E", o_res_E, hold_E);
      check("hold_M", o_res_M, hold_M);
    end
    start = 1'b0;
    finish_res("hold", 2);
    repeat (3) @(negedge clk);
    check("hold_start_ignored", o_busy, 0);

    // Abort during WAIT of block 2 of 4.
    start_job(4);
    k = 0;
    for (int c = 0; c < 100 && k < 2; c++) begin
      if (o_fmac_valid) k++;
      if (k < 2) @(negedge clk);
    end
    check("abort_saw_2_issues", k, 2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", o_busy, 0);
    check("abort_no_res", o_res_valid, 0);
    check("abort_acc_kept", o_res_M, 1);
    repeat (4) @(negedge clk);
    check("abort_no_more_pops", a_idx - start_a, 2);
    check("abort_res_stays_0", o_res_valid, 0);
    start_job(1);
    wait_res("after_abort");
    finish_res("after_abort", 1);

    // Abort in FETCH with both valid: readies forced low, no pop.
    start_job(3);
    abort = 1'b1;
    #1;
    check("abort_fetch_rdy", o_act_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("abort_fetch_idle", o_busy, 0);
    check("abort_fetch_no_pop", a_idx - start_a, 0);

    // Asynchronous reset mid-FETCH (streams idle so FETCH persists).
    mode = 2;
    start_job(3);
    @(negedge clk);
    check("fetch_busy", o_busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_act_E", o_fmac_Act_E, 0);
    check("arst_act_M", o_fmac_Act_M, 0);
    check("arst_ready", o_act_ready, 0);
    check("arst_res_valid", o_res_valid, 0);
    check("arst_res_M", o_res_M, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random jobs.
    for (int j = 0; j < 4; j++) begin
      mode = $urandom_range(0, 1);
      n = $urandom_range(1, 8);
      start_job(n);
      wait_res("rand");
      finish_res("rand", n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
